// File: rtl/dram_access_arbiter_pkg.sv
// rtl/dram_access_arbiter_pkg.sv - shared encodings for the DRAM access arbiter
// Purpose: owner encoding, FSM state type and the default burst-length field width
//          shared by dram_access_arbiter and dram_burst_counter.
// Ports:   none (package).
package dram_access_arbiter_pkg;

  localparam logic OWN_N = 1'b0;
  localparam logic OWN_H = 1'b1;

  localparam int LEN_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_N = 2'd1,
    BURST_H = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dram_burst_counter.sv
// rtl/dram_burst_counter.sv - burst address sequencer and remaining-beat counter
// Purpose: loads a burst start address and length, then on every step advances
//          the address (wrapping modulo 2^AWIDTH) and counts the remaining beats down.
// Ports:
//   clk      in   clock
//   reset_i  in   synchronous active-high reset
//   load_i   in   capture addr_i/len_i as a new burst
//   step_i   in   one beat issued this cycle
//   addr_i   in   burst start address
//   len_i    in   burst beats-1
//   addr_o   out  address of the current beat
//   last_o   out  current beat is the last one of the burst
module dram_burst_counter #(
  parameter int AWIDTH    = 10,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [AWIDTH-1:0]    addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic [AWIDTH-1:0]    addr_o,
  output logic                 last_o
);

  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = addr_i;
      remain_d = len_i;
    end else if (step_i) begin
      // Natural overflow of the AWIDTH-bit add gives the required wrap to 0.
      addr_d   = addr_q + AWIDTH'(1);
      remain_d = remain_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == '0);

endmodule

// File: rtl/dram_access_arbiter.sv
// rtl/dram_access_arbiter.sv - burst arbiter sharing one DRAM port between NPU and host
// Purpose: grants whole bursts to port N (NPU) or port H (host), sequences beat
//          addresses, muxes write data onto the DRAM and steers read-valid back.
//          Ties are round-robin by default; define DRAM_ARB_FIXED_PRIO_EN to make
//          port N win every tie.
// Ports:
//   clk, reset_npu                      clock, synchronous active-high reset
//   n_req/n_we/n_addr/n_len/n_wdata     NPU burst request (held until n_done)
//   n_gnt/n_rvalid/n_done               NPU beat issued / read data valid / last beat
//   h_*                                 same set for the host port
//   dram_addr/dram_we/dram_wdata        DRAM command outputs (zero outside bursts)
//   dram_rdata                          DRAM read data (1-cycle latency)
//   rdata                               dram_rdata passed through to both ports
module dram_access_arbiter
  import dram_access_arbiter_pkg::*;
#(
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 80,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_npu,
  input  logic                 n_req,
  input  logic                 n_we,
  input  logic [AWIDTH-1:0]    n_addr,
  input  logic [LEN_WIDTH-1:0] n_len,
  input  logic [DWIDTH-1:0]    n_wdata,
  output logic                 n_gnt,
  output logic                 n_rvalid,
  output logic                 n_done,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [AWIDTH-1:0]    h_addr,
  input  logic [LEN_WIDTH-1:0] h_len,
  input  logic [DWIDTH-1:0]    h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic                 h_done,
  output logic [AWIDTH-1:0]    dram_addr,
  output logic                 dram_we,
  output logic [DWIDTH-1:0]    dram_wdata,
  input  logic [DWIDTH-1:0]    dram_rdata,
  output logic [DWIDTH-1:0]    rdata
);

  arb_state_e state_q, state_d;
  logic       we_q, we_d;
  logic       n_rv_q, h_rv_q;
  logic       pick_n;
  logic       cnt_load, cnt_step, cnt_last;
  logic [AWIDTH-1:0]    cnt_addr, ld_addr;
  logic [LEN_WIDTH-1:0] ld_len;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign pick_n = n_req;
`else
  logic last_owner_q, last_owner_d;
  // N takes a tie only when H owned the previous burst.
  assign pick_n = n_req & (~h_req | (last_owner_q == OWN_H));
`endif

  assign ld_addr = pick_n ? n_addr : h_addr;
  assign ld_len  = pick_n ? n_len  : h_len;

  dram_burst_counter #(
    .AWIDTH   (AWIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) u_cnt (
    .clk    (clk),
    .reset_i(reset_npu),
    .load_i (cnt_load),
    .step_i (cnt_step),
    .addr_i (ld_addr),
    .len_i  (ld_len),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    n_gnt      = 1'b0;
    h_gnt      = 1'b0;
    n_done     = 1'b0;
    h_done     = 1'b0;
    dram_addr  = '0;
    dram_we    = 1'b0;
    dram_wdata = '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_n) begin
          state_d  = BURST_N;
          we_d     = n_we;
          cnt_load = 1'b1;
`ifndef DRAM_ARB_FIXED_PRIO_EN
          last_owner_d = OWN_N;
`endif
        end else if (h_req) begin
          state_d  = BURST_H;
          we_d     = h_we;
          cnt_load = 1'b1;
`ifndef DRAM_ARB_FIXED_PRIO_EN
          last_owner_d = OWN_H;
`endif
        end
      end
      BURST_N: begin
        dram_addr  = cnt_addr;
        dram_we    = we_q;
        dram_wdata = n_wdata;
        n_gnt      = 1'b1;
        cnt_step   = 1'b1;
        if (cnt_last) begin
          n_done  = 1'b1;
          state_d = IDLE;
        end
      end
      BURST_H: begin
        dram_addr  = cnt_addr;
        dram_we    = we_q;
        dram_wdata = h_wdata;
        h_gnt      = 1'b1;
        cnt_step   = 1'b1;
        if (cnt_last) begin
          h_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_npu) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      n_rv_q  <= 1'b0;
      h_rv_q  <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      last_owner_q <= OWN_H;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      // DRAM returns read data one cycle after the address beat.
      n_rv_q  <= n_gnt & ~we_q;
      h_rv_q  <= h_gnt & ~we_q;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign n_rvalid = n_rv_q;
  assign h_rvalid = h_rv_q;
  assign rdata    = dram_rdata;

endmodule
